// File: rtl/store_buffer.sv
// Store buffer: holds mem-stage stores until ROB commit, drains them in order to the dcache,
// forwards word data to younger loads and flushes uncommitted stores on exception.
module store_buffer #(
  parameter int unsigned N               = 4,
  parameter int unsigned WORD_SIZE       = 32,
  parameter int unsigned ROB_ENTRY_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [WORD_SIZE-1:0]       st_addr,
  input  logic [WORD_SIZE-1:0]       st_data,
  input  logic                       st_is_byte,
  input  logic [ROB_ENTRY_WIDTH-1:0] st_rob_id,
  output logic                       full,
  output logic                       empty,
  input  logic                       sb_store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id,
  input  logic                       exception,
  input  logic                       ld_valid,
  input  logic [WORD_SIZE-1:0]       ld_addr,
  output logic                       fwd_hit,
  output logic [WORD_SIZE-1:0]       fwd_data,
  output logic                       fwd_stall,
  output logic                       cache_req_valid,
  input  logic                       cache_ready,
  output logic [WORD_SIZE-1:0]       cache_addr,
  output logic [WORD_SIZE-1:0]       cache_data,
  output logic                       cache_is_byte
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = PW + 1;

  logic [N-1:0]               valid_q, valid_d;
  logic [N-1:0]               committed_q, committed_d;
  logic [N-1:0]               is_byte_q;
  logic [WORD_SIZE-1:0]       addr_q [N];
  logic [WORD_SIZE-1:0]       data_q [N];
  logic [ROB_ENTRY_WIDTH-1:0] rob_q  [N];
  logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]              count_q, count_d, kept;
  logic                       alloc, pop;
  logic [PW-1:0]              idx;

  assign full            = (count_q == CW'(N));
  assign empty           = (count_q == '0);
  assign cache_req_valid = valid_q[head_q] & committed_q[head_q];
  assign cache_addr      = addr_q[head_q];
  assign cache_data      = data_q[head_q];
  assign cache_is_byte   = is_byte_q[head_q];
  assign pop             = cache_req_valid & cache_ready;
  assign alloc           = st_valid & ~full & ~exception;

  // Order matters: permission, then pop, then allocate, then the flush trims to the committed prefix.
  always_comb begin : next_state
    valid_d     = valid_q;
    committed_d = committed_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    kept        = '0;
    if (sb_store_permission) begin
      for (int i = 0; i < int'(N); i++) begin
        if (valid_q[i] && !committed_q[i] && rob_q[i] == sb_rob_id) committed_d[i] = 1'b1;
      end
    end
    if (pop) begin
      valid_d[head_q]     = 1'b0;
      committed_d[head_q] = 1'b0;
      head_d              = head_q + PW'(1);
      count_d             = count_d - CW'(1);
    end
    if (alloc) begin
      valid_d[tail_q]     = 1'b1;
      committed_d[tail_q] = sb_store_permission && (st_rob_id == sb_rob_id);
      tail_d              = tail_q + PW'(1);
      count_d             = count_d + CW'(1);
    end
    if (exception) begin
      valid_d     = valid_d & committed_d;
      committed_d = committed_d & valid_d;
      for (int i = 0; i < int'(N); i++) kept = kept + CW'(valid_d[i]);
      count_d = kept;
      tail_d  = head_d + PW'(kept);
    end
  end

  always_ff @(posedge clk) begin : ctrl_regs
    if (!rst) begin
      valid_q     <= '0;
      committed_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      committed_q <= committed_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin : payload_regs
    if (alloc) begin
      addr_q[tail_q]    <= st_addr;
      data_q[tail_q]    <= st_data;
      is_byte_q[tail_q] <= st_is_byte;
      rob_q[tail_q]     <= st_rob_id;
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin : forward
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    idx       = '0;
    if (ld_valid) begin
      for (int k = 0; k < int'(N); k++) begin
        idx = head_q + PW'(k);
        if (valid_q[idx] && addr_q[idx][WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2]) begin
          fwd_hit   = ~is_byte_q[idx];
          fwd_stall = is_byte_q[idx];
          fwd_data  = is_byte_q[idx] ? '0 : data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer: allocation, commit/drain handshake, full handling,
// load forwarding, exception flush with pointer wrap, and mid-drain reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid, st_is_byte, sb_store_permission, exception, ld_valid, cache_ready;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [2:0]  st_rob_id, sb_rob_id;
  logic        full, empty, fwd_hit, fwd_stall, cache_req_valid, cache_is_byte;
  logic [31:0] fwd_data, cache_addr, cache_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_buffer #(.N(4), .WORD_SIZE(32), .ROB_ENTRY_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_is_byte(st_is_byte),
    .st_rob_id(st_rob_id), .full(full), .empty(empty),
    .sb_store_permission(sb_store_permission), .sb_rob_id(sb_rob_id), .exception(exception),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .fwd_stall(fwd_stall), .cache_req_valid(cache_req_valid), .cache_ready(cache_ready),
    .cache_addr(cache_addr), .cache_data(cache_data), .cache_is_byte(cache_is_byte)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b,
                       input logic [2:0] id);
    st_valid = 1'b1; st_addr = a; st_data = d; st_is_byte = b; st_rob_id = id;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic commit(input logic [2:0] id);
    sb_store_permission = 1'b1; sb_rob_id = id;
    tick();
    sb_store_permission = 1'b0;
  endtask

  task automatic drain_one(input string tag, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_req"}, 32'(cache_req_valid), 32'd1);
    check({tag, "_addr"}, cache_addr, a);
    check({tag, "_data"}, cache_data, d);
    cache_ready = 1'b1;
    tick();
    cache_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_is_byte = 1'b0; st_rob_id = '0;
    sb_store_permission = 1'b0; sb_rob_id = '0; exception = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; cache_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // 1: reset state, three stores, nothing drains while uncommitted
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_req", 32'(cache_req_valid), 32'd0);
    check("rst_count", 32'(dut.count_q), 32'd0);
    cache_ready = 1'b1;
    store(32'h100, 32'hA, 1'b0, 3'd1);
    store(32'h104, 32'hB, 1'b0, 3'd2);
    store(32'h108, 32'hC, 1'b0, 3'd3);
    check("t1_count", 32'(dut.count_q), 32'd3);
    check("t1_req", 32'(cache_req_valid), 32'd0);
    check("t1_empty", 32'(empty), 32'd0);

    // 2: commit latency, stall stability, in-order commit gating
    cache_ready = 1'b0;
    commit(3'd1);
    for (int c = 0; c < 3; c++) begin
      check("t2_req_hold", 32'(cache_req_valid), 32'd1);
      check("t2_addr_hold", cache_addr, 32'h100);
      check("t2_data_hold", cache_data, 32'hA);
      tick();
    end
    drain_one("t2_id1", 32'h100, 32'hA);
    check("t2_count", 32'(dut.count_q), 32'd2);
    check("t2_id2_wait", 32'(cache_req_valid), 32'd0);
    commit(3'd2);
    commit(3'd3);
    drain_one("t2_id2", 32'h104, 32'hB);
    drain_one("t2_id3", 32'h108, 32'hC);
    check("t2_empty", 32'(empty), 32'd1);

    // 3: fill, overflow ignored, pop plus store in one cycle drops the store
    for (int i = 0; i < 4; i++) store(32'h300 + 32'(4 * i), 32'(i + 1), 1'b0, 3'(i));
    check("t3_full", 32'(full), 32'd1);
    store(32'h400, 32'h99, 1'b0, 3'd4);
    check("t3_ovf_count", 32'(dut.count_q), 32'd4);
    commit(3'd0);
    check("t3_req", 32'(cache_req_valid), 32'd1);
    cache_ready = 1'b1;
    store(32'h500, 32'h55, 1'b0, 3'd5);
    cache_ready = 1'b0;
    check("t3_pop_st_count", 32'(dut.count_q), 32'd3);
    check("t3_pop_st_full", 32'(full), 32'd0);
    commit(3'd1); commit(3'd2); commit(3'd3);
    drain_one("t3_e1", 32'h304, 32'd2);
    drain_one("t3_e2", 32'h308, 32'd3);
    drain_one("t3_e3", 32'h30C, 32'd4);
    check("t3_empty", 32'(empty), 32'd1);

    // 4: forwarding, youngest wins, byte store stalls
    store(32'h200, 32'h11, 1'b0, 3'd1);
    store(32'h200, 32'h22, 1'b0, 3'd2);
    ld_valid = 1'b1; ld_addr = 32'h202; #1;
    check("t4_hit", 32'(fwd_hit), 32'd1);
    check("t4_data", fwd_data, 32'h22);
    check("t4_nostall", 32'(fwd_stall), 32'd0);
    ld_valid = 1'b0;
    store(32'h201, 32'h33, 1'b1, 3'd3);
    ld_valid = 1'b1; #1;
    check("t4_stall", 32'(fwd_stall), 32'd1);
    check("t4_stall_nohit", 32'(fwd_hit), 32'd0);
    ld_addr = 32'h204; #1;
    check("t4_miss_hit", 32'(fwd_hit), 32'd0);
    check("t4_miss_stall", 32'(fwd_stall), 32'd0);
    ld_addr = 32'h200; ld_valid = 1'b0; #1;
    check("t4_ldoff_stall", 32'(fwd_stall), 32'd0);
    commit(3'd1); commit(3'd2); commit(3'd3);
    drain_one("t4_e1", 32'h200, 32'h11);
    drain_one("t4_e2", 32'h200, 32'h22);
    ld_valid = 1'b1; #1;
    check("t4_pop_stall", 32'(fwd_stall), 32'd1);
    check("t4_isbyte", 32'(cache_is_byte), 32'd1);
    drain_one("t4_e3", 32'h201, 32'h33);
    ld_valid = 1'b0;
    check("t4_empty", 32'(empty), 32'd1);

    // 5: exception flush keeps committed prefix, then wrap and order
    store(32'h600, 32'h40, 1'b0, 3'd4);
    store(32'h604, 32'h50, 1'b0, 3'd5);
    store(32'h608, 32'h60, 1'b0, 3'd6);
    commit(3'd4);
    exception = 1'b1;
    tick();
    exception = 1'b0;
    check("t5_count", 32'(dut.count_q), 32'd1);
    ld_valid = 1'b1; ld_addr = 32'h604; #1;
    check("t5_flushed_fwd", 32'(fwd_hit), 32'd0);
    ld_valid = 1'b0;
    drain_one("t5_id4", 32'h600, 32'h40);
    check("t5_empty", 32'(empty), 32'd1);
    store(32'h700, 32'h70, 1'b0, 3'd0);
    store(32'h704, 32'h71, 1'b0, 3'd1);
    store(32'h708, 32'h72, 1'b0, 3'd2);
    commit(3'd0); commit(3'd1); commit(3'd2);
    drain_one("t5_w0", 32'h700, 32'h70);
    drain_one("t5_w1", 32'h704, 32'h71);
    drain_one("t5_w2", 32'h708, 32'h72);
    store(32'h900, 32'h91, 1'b0, 3'd5);
    store(32'h904, 32'h92, 1'b0, 3'd6);
    sb_store_permission = 1'b1; sb_rob_id = 3'd5; exception = 1'b1;
    tick();
    sb_store_permission = 1'b0; exception = 1'b0;
    check("t5_perm_exc_count", 32'(dut.count_q), 32'd1);
    drain_one("t5_perm_exc", 32'h900, 32'h91);
    check("t5_perm_exc_empty", 32'(empty), 32'd1);

    // 6: reset while a drain request is pending
    store(32'h800, 32'h88, 1'b0, 3'd7);
    commit(3'd7);
    check("t6_req_pre", 32'(cache_req_valid), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ld_valid = 1'b1; ld_addr = 32'h800; #1;
    check("t6_req", 32'(cache_req_valid), 32'd0);
    check("t6_full", 32'(full), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_count", 32'(dut.count_q), 32'd0);
    check("t6_hit", 32'(fwd_hit), 32'd0);
    check("t6_stall", 32'(fwd_stall), 32'd0);
    ld_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
